tf32_mul_arbiter: RTL and testbench



---
 rtl/tf32_arb_if.sv | 22 ++
 rtl/tf32_mul_arbiter.sv | 129 ++++++++++++
 tb/tb_tf32_mul_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/tf32_arb_if.sv
// Requester-side handshake bundle for the shared TF32 multiplier arbiter.
// Operand buses pack requester i into bits [19i+18:19i].
interface tf32_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [19*NUM_REQ-1:0] req_a;
  logic [19*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [18:0]           rsp_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/tf32_mul_arbiter.sv
// Round-robin arbiter feeding a two-stage pipelined TF32 multiplier (RNE, saturating).
// Optional issued-operation counter enabled by defining TF32_ARB_OPCNT_EN.
module tf32_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic        clk,
  input  logic        rst,
  tf32_arb_if.slave   bus,
  output logic [15:0] op_count
);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               found;
  logic               xfer;
  int                 idx;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  assign bus.req_ready = grant;
  assign xfer          = found;

  // Stage 1: captured operands and owner index.
  logic            s1_valid;
  logic [18:0]     s1_a;
  logic [18:0]     s1_b;
  logic [ID_W-1:0] s1_id;

  // TF32 product of the stage-1 operands.
  logic [21:0] prod;
  logic        norm;
  logic [9:0]  mant_t;
  logic        guard;
  logic        sticky;
  logic [10:0] mant_r;
  logic [9:0]  exp_sum;
  logic        sign;
  logic [18:0] prod_res;

  always_comb begin
    prod   = 22'({1'b1, s1_a[9:0]}) * 22'({1'b1, s1_b[9:0]});
    norm   = prod[21];
    if (norm) begin
      mant_t = prod[20:11];
      guard  = prod[10];
      sticky = |prod[9:0];
    end else begin
      mant_t = prod[19:10];
      guard  = prod[9];
      sticky = |prod[8:0];
    end
    mant_r  = {1'b0, mant_t} + 11'(guard & (sticky | mant_t[0]));
    // Biased sum still carries the +127 excess; a rounding carry bumps the exponent.
    exp_sum = 10'(s1_a[17:10]) + 10'(s1_b[17:10]) + 10'(norm) + 10'(mant_r[10]);
    sign    = s1_a[18] ^ s1_b[18];
    if (s1_a[17:0] == '0 || s1_b[17:0] == '0)
      prod_res = '0;
    else if (exp_sum >= 10'd382)
      prod_res = {sign, 8'hFE, 10'h3FF};
    else if (exp_sum <= 10'd127)
      prod_res = '0;
    else
      prod_res = {sign, 8'(exp_sum - 10'd127), mant_r[9:0]};
  end

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [18:0]        rsp_data_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      s1_valid    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      s1_valid    <= xfer;
      if (xfer)
        ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      rsp_valid_q <= s1_valid ? (NUM_REQ'(1) << s1_id) : '0;
      rsp_data_q  <= prod_res;
    end
  end

  // NOTE: stage-1 payload is qualified by s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      s1_a  <= bus.req_a[19*grant_id +: 19];
      s1_b  <= bus.req_b[19*grant_id +: 19];
      s1_id <= grant_id;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

`ifdef TF32_ARB_OPCNT_EN
  logic [15:0] op_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      op_cnt_q <= '0;
    else if (xfer)
      op_cnt_q <= op_cnt_q + 16'd1;
  end

  assign op_count = op_cnt_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_tf32_mul_arbiter.sv
// Scoreboard bench for tf32_mul_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them against rsp_valid/rsp_data.
module tb_tf32_mul_arbiter;
  localparam int NUM_REQ = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] op_count;

  tf32_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

  tf32_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [18:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [18:0] exp_p[NUM_REQ];
  int          cyc      = 0;
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] xfers    = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any response, or any entry now due, is compared against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid != '0 || (sb.size() > 0 && sb[0].cyc <= cyc)) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.id);
        check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic set_op(input int i, input logic [18:0] a, input logic [18:0] b, input logic [18:0] p);
    bus.req_a[19*i +: 19] = a;
    bus.req_b[19*i +: 19] = b;
    exp_p[i] = p;
  endtask

  // One cycle: drive req_valid, check the grant mid-cycle, record the expected response.
  task automatic drive(input logic [3:0] valid, input logic [3:0] exp_ready, input string name);
    bus.req_valid = valid;
    @(negedge clk);
    check(name, 32'(bus.req_ready), 32'(exp_ready));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_ready[i]) begin
        sb.push_back('{i, exp_p[i], cyc + 2});
        xfers = xfers + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [18:0] vec_a[8] = '{19'h5FC00, 19'h40000, 19'h3FBFF, 19'h5FC00,
                            19'h00400, 19'h1FC01, 19'h1FC03, 19'h1FE01};
  logic [18:0] vec_b[8] = '{19'h1FC00, 19'h20000, 19'h20000, 19'h60000,
                            19'h00400, 19'h1FE00, 19'h1FE00, 19'h1FE01};
  logic [18:0] vec_p[8] = '{19'h5FC00, 19'h00000, 19'h3FBFF, 19'h20000,
                            19'h00000, 19'h1FE02, 19'h1FE04, 19'h20082};

  initial begin
    logic [3:0] rr;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) exp_p[i] = '0;

    @(negedge clk);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);
    check("reset_ready_idle", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Round-robin with all requesters active: 1.5 * 1.5 = 2.25.
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 19'h1FE00, 19'h1FE00, 19'h20080);
    drive(4'b1111, 4'b0001, "rr_grant0");
    drive(4'b1111, 4'b0010, "rr_grant1");
    drive(4'b1111, 4'b0100, "rr_grant2");
    drive(4'b1111, 4'b1000, "rr_grant3");
    drive(4'b1111, 4'b0001, "rr_grant4");

    // Single request: 1.0 * 2.0 = 2.0.
    set_op(0, 19'h1FC00, 19'h20000, 19'h20000);
    drive(4'b0001, 4'b0001, "single_grant");
    repeat (3) drive(4'b0000, 4'b0000, "single_idle");

    // Back-to-back on requester 3: sign, zero, saturation, underflow, rounding.
    for (int v = 0; v < 8; v++) begin
      set_op(3, vec_a[v], vec_b[v], vec_p[v]);
      drive(4'b1000, 4'b1000, "vec_grant");
    end
    drive(4'b0000, 4'b0000, "vec_idle");

    // Move ptr to 2, then skip past idle requesters and withdraw requester 1.
    set_op(1, 19'h1FC00, 19'h1FC00, 19'h1FC00);
    drive(4'b0010, 4'b0010, "skip_setup");
    set_op(0, 19'h20000, 19'h20000, 19'h20400);
    drive(4'b0011, 4'b0001, "skip_wrap");
    drive(4'b0000, 4'b0000, "withdraw");
    set_op(2, 19'h1FE00, 19'h20000, 19'h20200);
    drive(4'b0101, 4'b0100, "ptr_hold");

    // Reset one cycle after a transfer discards it and restores priority to 0.
    rst = 1'b1;
    bus.req_valid = '0;
    sb.delete();
    xfers = 16'd0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_op_count", 32'(op_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 19'h1FE00, 19'h1FE00, 19'h20080);
    drive(4'b1111, 4'b0001, "post_rst_grant");

    // 70000 back-to-back transfers in total since the reset.
    for (int n = 1; n < 70000; n++) begin
      rr = 4'b0001 << (n % 4);
      drive(4'b1111, rr, "cnt_grant");
    end
    drive(4'b0000, 4'b0000, "cnt_idle");
`ifdef TF32_ARB_OPCNT_EN
    check("op_count_model", 32'(op_count), 32'(xfers));
    check("op_count_wrap", 32'(op_count), 32'd4464);
`else
    check("op_count_tied", 32'(op_count), 32'd0);
`endif

    repeat (3) drive(4'b0000, 4'b0000, "drain_idle");
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
